// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle control sequencer for the 8-bit regfile/alu datapath.
// Takes one 16-bit instruction per valid/ready handshake. It walks
// IDLE -> DECODE -> EXEC -> WB and drives the regfile address, ALU select,
// write-data select and regwrite outputs. It owns the PC and resolves BEQ.
// Ports: clk, reset (sync, active-high), instr/instr_valid/instr_ready,
//        zero (ALU flag), ra1/ra2/wa, regwrite, alu_ctrl, wd_sel, imm,
//        pc, halted, illegal.
// Option: define EXEC_CTRL_R0_ZERO_EN to make r0 read-only. With it,
//         regwrite is suppressed when wa = 0.
module exec_ctrl #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            zero,
    output logic [2:0]      ra1,
    output logic [2:0]      ra2,
    output logic [2:0]      wa,
    output logic            regwrite,
    output logic [2:0]      alu_ctrl,
    output logic            wd_sel,
    output logic [7:0]      imm,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      alu_q, alu_d;
    logic            wd_sel_q, wd_sel_d;
    logic            regwrite_q, regwrite_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      op_q;
    logic [3:0]      op_in;
    logic [5:0]      br_off;
    logic [PC_W-1:0] br_sext;
    logic            wr_en;

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        logic [2:0] r;
        r = 3'b000;
        unique case (op)
            OP_ADD:  r = 3'b010;
            OP_SUB:  r = 3'b110;
            OP_OR:   r = 3'b001;
            OP_SLT:  r = 3'b111;
            OP_BEQ:  r = 3'b110;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic is_write(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LI);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_BEQ) || (op == OP_HALT);
    endfunction

    assign op_q    = ir_q[15:12];
    assign op_in   = instr[15:12];
    assign br_off  = {ir_q[11:9], ir_q[2:0]};
    assign br_sext = {{(PC_W-6){br_off[5]}}, br_off};

`ifdef EXEC_CTRL_R0_ZERO_EN
    assign wr_en = (ir_q[11:9] != 3'd0);
`else
    assign wr_en = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        alu_d      = alu_q;
        wd_sel_d   = 1'b0;
        regwrite_d = 1'b0;
        illegal_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d      = instr;
                    pc_d      = pc_q + PC_W'(1);
                    // registered pulse lands in the DECODE cycle
                    illegal_d = !is_legal(op_in);
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_q == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    alu_d   = alu_of(op_q);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((op_q == OP_BEQ) && zero) begin
                    pc_d = pc_q + br_sext;
                end
                if (is_write(op_q)) begin
                    regwrite_d = wr_en;
                    wd_sel_d   = (op_q == OP_LI);
                    state_d    = S_WB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            pc_q       <= '0;
            alu_q      <= 3'b000;
            wd_sel_q   <= 1'b0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            alu_q      <= alu_d;
            wd_sel_q   <= wd_sel_d;
            regwrite_q <= regwrite_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign halted      = (state_q == S_HALT);
    assign ra1         = ir_q[8:6];
    assign ra2         = ir_q[5:3];
    assign wa          = ir_q[11:9];
    assign imm         = ir_q[7:0];
    assign pc          = pc_q;
    assign alu_ctrl    = alu_q;
    assign wd_sel      = wd_sel_q;
    assign regwrite    = regwrite_q;
    assign illegal     = illegal_q;

endmodule
